fft_mod1_bfly10: RTL
====================

Name: fft_mod1_bfly10

Overview:
- First butterfly stage of module1 in the 16-lane FFT pipeline.
- Sits directly downstream of module0's CBFP0 output and consumes its 11-bit data and valid_mod1 strobe.
- Pairs points 32 apart (2 clock blocks apart) and outputs full-precision add/sub buses with an alert strobe.
- The alert strobe drives the next module1 sub-stage, which applies the twiddle factors.

Parameters:
- DATA_WIDTH, 11, input sample width, signed.
- NUM_IN_OUT, 16, lanes per clock.
- FRAME_CYC, 32, valid cycles per frame (512 points / 16 lanes).
- DIST_CYC, 2, butterfly partner distance in cycles (32 points).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- valid_mod1  in  1  input data valid, one 16-lane block per high cycle.
- din_R  in  signed [10:0] x [0:15]  real lanes.
- din_Q  in  signed [10:0] x [0:15]  imaginary lanes.
- dout_R_add  out  signed [11:0] x [0:15]  real first + second.
- dout_R_sub  out  signed [11:0] x [0:15]  real first - second.
- dout_Q_add  out  signed [11:0] x [0:15]  imag first + second.
- dout_Q_sub  out  signed [11:0] x [0:15]  imag first - second.
- alert_mod11  out  1  output buses hold a new result this cycle.
- frame_done  out  1  one-cycle pulse with the last result of a frame.

Behaviour:
- Reset: async on rst high. All dout lanes = 0, alert_mod11 = 0, frame_done = 0, cycle counter = 0, delay buffer = 0. Outputs stay 0 while rst is high.
- Cycle counter cnt (5-bit, 0..31):
  - Advances only on clk edges where valid_mod1 = 1; wraps 31 -> 0.
  - Frames may follow back-to-back with no gap.
- Phase decode on each valid cycle: ph = cnt[1:0].
  - ph 0,1 (FIRST): store the input block in buffer slot ph[0]. No output.
  - ph 2,3 (SECOND): pair the input with buffer slot ph[0] and compute the butterfly.
- Butterfly:
  - Sign-extend both operands to 12 bits.
  - add = first + second; sub = first - second, lane-wise for R and Q.
  - Full precision; no saturation or rounding. Range -2048..+2047 cannot overflow from 11-bit inputs.
- Latency: outputs registered, appearing 1 clk after the SECOND block is sampled.
- alert_mod11:
  - High for exactly the cycle after each SECOND valid cycle.
  - Pattern for an uninterrupted frame: relative to the first valid edge, high in cycles 3,4,7,8,...,31,32. That is 16 high cycles per frame.
- Output hold: when alert_mod11 = 0, dout holds its last value (no clearing).
- frame_done: high together with alert_mod11 for the result of cnt = 31.
- Valid gaps:
  - valid_mod1 may drop at any cycle, including mid-frame.
  - cnt and the buffer freeze; no result or alert is produced for idle cycles.
  - Pairing resumes correctly on the next valid cycle.
- Reset mid-frame: the partial frame is discarded. The first valid after release is treated as cnt = 0.
- Lanes are independent; lane i pairs only with lane i.

Test Plan:
- Reset check: assert rst with inputs non-zero and valid_mod1 = 1 -> all outputs 0, alert_mod11 = 0, frame_done = 0 during and 1 clk after reset.
- Single frame, 32 valid cycles:
  - Stimulus: din_R[i] = cycle index c, din_Q[i] = -c for all lanes.
  - Required at c = 2: dout_R_add = 2, dout_R_sub = -2, dout_Q_add = -2, dout_Q_sub = +2.
  - Required overall: alert_mod11 asserted 16 times; frame_done a single pulse with the c = 31 result (R_add = 29 + 31 = 60).
- Extremes:
  - FIRST 1023 / SECOND -1024 -> R_add = -1, R_sub = 2047.
  - FIRST -1024 / SECOND -1024 -> R_add = -2048, R_sub = 0.
  - FIRST -1024 / SECOND 1023 -> R_sub = -2047.
- Valid gap: drop valid_mod1 for 5 cycles between c = 2 and c = 3 -> no alert during the gap; the c = 3 result pairs with c = 1 data. Total results and frame_done timing are unchanged relative to valid count.
- Back-to-back frames: 64 consecutive valids -> 32 alerts, frame_done pulses after valid 32 and valid 64. Second-frame results are correct with no cross-frame pairing.
- Reset mid-frame: apply rst after 13 valids, then 32 valids -> results match a fresh frame exactly; exactly 1 frame_done.

Source files
------------

// File: rtl/fft_mod1_bfly10.sv
// First module1 butterfly: pairs 16-lane blocks that sit two valid cycles apart.
// Produces full-precision add/sub lanes plus an alert strobe for the twiddle stage.
module fft_mod1_bfly10 #(
    parameter int DATA_WIDTH = 11,
    parameter int NUM_IN_OUT = 16,
    parameter int FRAME_CYC  = 32,
    parameter int DIST_CYC   = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_mod1,
    input  logic signed [DATA_WIDTH-1:0] din_R      [0:NUM_IN_OUT-1],
    input  logic signed [DATA_WIDTH-1:0] din_Q      [0:NUM_IN_OUT-1],
    output logic signed [DATA_WIDTH:0]   dout_R_add [0:NUM_IN_OUT-1],
    output logic signed [DATA_WIDTH:0]   dout_R_sub [0:NUM_IN_OUT-1],
    output logic signed [DATA_WIDTH:0]   dout_Q_add [0:NUM_IN_OUT-1],
    output logic signed [DATA_WIDTH:0]   dout_Q_sub [0:NUM_IN_OUT-1],
    output logic                         alert_mod11,
    output logic                         frame_done
);

    localparam int CNT_W  = $clog2(FRAME_CYC);
    localparam int SLOT_W = $clog2(DIST_CYC);
    localparam int PH_W   = SLOT_W + 1;

    typedef logic signed [DATA_WIDTH-1:0] smp_t;
    typedef logic signed [DATA_WIDTH:0]   wide_t;

    function automatic wide_t sext(input smp_t x);
        return {x[DATA_WIDTH-1], x};
    endfunction

    function automatic wide_t bfly_add(input smp_t a, input smp_t b);
        return sext(a) + sext(b);
    endfunction

    function automatic wide_t bfly_sub(input smp_t a, input smp_t b);
        return sext(a) - sext(b);
    endfunction

    logic [CNT_W-1:0] cnt_q, cnt_d;
    smp_t  buf_R_q [0:DIST_CYC-1][0:NUM_IN_OUT-1];
    smp_t  buf_R_d [0:DIST_CYC-1][0:NUM_IN_OUT-1];
    smp_t  buf_Q_q [0:DIST_CYC-1][0:NUM_IN_OUT-1];
    smp_t  buf_Q_d [0:DIST_CYC-1][0:NUM_IN_OUT-1];
    wide_t radd_q [0:NUM_IN_OUT-1], radd_d [0:NUM_IN_OUT-1];
    wide_t rsub_q [0:NUM_IN_OUT-1], rsub_d [0:NUM_IN_OUT-1];
    wide_t qadd_q [0:NUM_IN_OUT-1], qadd_d [0:NUM_IN_OUT-1];
    wide_t qsub_q [0:NUM_IN_OUT-1], qsub_d [0:NUM_IN_OUT-1];
    logic  alert_q, alert_d;
    logic  fdone_q, fdone_d;

    // Upper phase bit selects FIRST (store) vs SECOND (compute); low bits pick the slot.
    logic [PH_W-1:0]   ph;
    logic [SLOT_W-1:0] slot;
    assign ph   = cnt_q[PH_W-1:0];
    assign slot = ph[SLOT_W-1:0];

    always_comb begin
        cnt_d   = cnt_q;
        buf_R_d = buf_R_q;
        buf_Q_d = buf_Q_q;
        radd_d  = radd_q;
        rsub_d  = rsub_q;
        qadd_d  = qadd_q;
        qsub_d  = qsub_q;
        alert_d = 1'b0;
        fdone_d = 1'b0;
        if (valid_mod1) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (!ph[PH_W-1]) begin
                buf_R_d[slot] = din_R;
                buf_Q_d[slot] = din_Q;
            end else begin
                alert_d = 1'b1;
                fdone_d = (cnt_q == CNT_W'(FRAME_CYC - 1));
                for (int i = 0; i < NUM_IN_OUT; i++) begin
                    radd_d[i] = bfly_add(buf_R_q[slot][i], din_R[i]);
                    rsub_d[i] = bfly_sub(buf_R_q[slot][i], din_R[i]);
                    qadd_d[i] = bfly_add(buf_Q_q[slot][i], din_Q[i]);
                    qsub_d[i] = bfly_sub(buf_Q_q[slot][i], din_Q[i]);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            alert_q <= 1'b0;
            fdone_q <= 1'b0;
            for (int s = 0; s < DIST_CYC; s++) begin
                for (int i = 0; i < NUM_IN_OUT; i++) begin
                    buf_R_q[s][i] <= '0;
                    buf_Q_q[s][i] <= '0;
                end
            end
            for (int i = 0; i < NUM_IN_OUT; i++) begin
                radd_q[i] <= '0;
                rsub_q[i] <= '0;
                qadd_q[i] <= '0;
                qsub_q[i] <= '0;
            end
        end else begin
            cnt_q   <= cnt_d;
            alert_q <= alert_d;
            fdone_q <= fdone_d;
            buf_R_q <= buf_R_d;
            buf_Q_q <= buf_Q_d;
            radd_q  <= radd_d;
            rsub_q  <= rsub_d;
            qadd_q  <= qadd_d;
            qsub_q  <= qsub_d;
        end
    end

    assign dout_R_add  = radd_q;
    assign dout_R_sub  = rsub_q;
    assign dout_Q_add  = qadd_q;
    assign dout_Q_sub  = qsub_q;
    assign alert_mod11 = alert_q;
    assign frame_done  = fdone_q;

endmodule
